melody_sequencer: RTL

- Transport and tempo controller for the note-player datapath.
- Replaces the free-running step counter that drives the note multiplexer's 8-bit select.
- Adds play/pause/stop control, a programmable step duration, and an articulation gap so that repeated notes are heard as separate notes.
- Outputs `step` (the mux select) and `note_en`, which gates the selected note clock before the speaker pin.

---
 rtl/melody_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/melody_sequencer.sv
// Transport/tempo controller: play/pause/stop, step timing and articulation gap.
// Define MELODY_LOOP_EN to wrap to step 0 at song end instead of stopping in DONE.
module melody_sequencer #(
   parameter int unsigned STEP_TICKS = 12500000,
   parameter int unsigned GAP_TICKS  = 1250000,
   parameter int unsigned SONG_LEN   = 148,
   parameter int unsigned TICK_W     = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       play,
   input  logic       pause,
   input  logic       stop,
   output logic [7:0] step,
   output logic       note_en,
   output logic       playing,
   output logic       done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PLAY,
      S_PAUSE,
      S_DONE
   } state_t;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_TICKS - 1);
   localparam logic [7:0]        STEP_LAST = 8'(SONG_LEN - 1);
   localparam int unsigned       SOUND_TICKS = STEP_TICKS - GAP_TICKS;

   state_t            state_q, state_d;
   logic [7:0]        step_q, step_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic              note_en_q, note_en_d;
   logic              playing_q, playing_d;
   logic              done_q, done_d;
   logic              step_end;
   logic              last_step;

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      tick_d    = tick_q;
      done_d    = 1'b0;
      step_end  = (tick_q == TICK_LAST);
      last_step = (step_q == STEP_LAST);

      if (stop) begin
         state_d = S_IDLE;
         step_d  = '0;
         tick_d  = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (play) begin
                  state_d = S_PLAY;
                  step_d  = '0;
                  tick_d  = '0;
               end
            end
            S_PLAY: begin
               // A pause landing on a step end lets the advance finish first.
               if (pause && !step_end) begin
                  state_d = S_PAUSE;
               end else if (step_end) begin
                  tick_d = '0;
                  if (!last_step) begin
                     step_d = step_q + 8'd1;
                  end else begin
                     done_d = 1'b1;
`ifdef MELODY_LOOP_EN
                     step_d = '0;
`else
                     state_d = S_DONE;
`endif
                  end
                  if (pause && state_d == S_PLAY)
                     state_d = S_PAUSE;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            S_PAUSE: begin
               if (!pause && play)
                  state_d = S_PLAY;
            end
            S_DONE: begin
               if (play) begin
                  state_d = S_PLAY;
                  step_d  = '0;
                  tick_d  = '0;
               end
            end
            default: begin
               state_d = S_IDLE;
               step_d  = '0;
               tick_d  = '0;
            end
         endcase
      end

      playing_d = (state_d == S_PLAY);
      note_en_d = playing_d && (32'(tick_d) < SOUND_TICKS);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         step_q    <= '0;
         tick_q    <= '0;
         note_en_q <= 1'b0;
         playing_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         tick_q    <= tick_d;
         note_en_q <= note_en_d;
         playing_q <= playing_d;
         done_q    <= done_d;
      end
   end

   assign step    = step_q;
   assign note_en = note_en_q;
   assign playing = playing_q;
   assign done    = done_q;

endmodule
